uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have input port clk (1 bit): system clock, with all state updated on the rising edge.
REQ-002 The block SHALL have input port rst (1 bit): asynchronous, active-high reset.
REQ-003 The block SHALL have input port tx_start (1 bit): request to transmit tx_data; qualified by tx_ready.
REQ-004 The block SHALL have input port tx_data (8 bits): frame payload, sent LSB first.
REQ-005 The block SHALL have input port data_size (4 bits): number of data bits, legal range 5-8.
REQ-006 The block SHALL have input port bit_period (14 bits): clock cycles per serial bit.
REQ-007 The block SHALL have output port serial_out (1 bit): UART line, idle high.
REQ-008 The block SHALL have output port tx_ready (1 bit): high when a new frame can be accepted.
REQ-009 The block SHALL have output port tx_done (1 bit): one-cycle pulse at frame completion.

Function
REQ-010 The block SHALL implement the states IDLE, START, DATA, PARITY (only with the macro) and STOP.
REQ-011 Accept: a rising edge with tx_start=1 and tx_ready=1 SHALL capture tx_data, data_size and bit_period into internal registers and move to START.
REQ-012 Later changes on tx_data, data_size and bit_period SHALL NOT affect the frame in flight.
REQ-013 tx_start while tx_ready=0 SHALL be ignored, with no queuing.
REQ-014 tx_ready SHALL be 1 only in IDLE; it SHALL drop in the cycle after accept.
REQ-015 serial_out SHALL be driven from a register, with no combinational path from inputs.
REQ-016 serial_out SHALL be 0 starting the first cycle after accept.
REQ-017 Each bit (start, data, parity, stop) SHALL last exactly P cycles, where P = the captured bit_period.
REQ-018 A captured bit_period below 2 SHALL be treated as P=2.
REQ-019 Bit timing SHALL use a cycle counter that restarts on every bit boundary, plus a bit index counter that rolls over at the captured data_size.
REQ-020 Data bits SHALL be sent as tx_data[0] through tx_data[data_size-1]; the upper bits SHALL be ignored.
REQ-021 A captured data_size below 5 SHALL be treated as 5; above 8 SHALL be treated as 8.
REQ-022 The stop bit SHALL be 1 for P cycles.
REQ-023 On the last cycle of the stop bit the block SHALL return to IDLE, with tx_ready=1 and tx_done=1 for exactly that following cycle.
REQ-024 Frame length from accept to the tx_done cycle SHALL be (2 + N [+1 parity]) * P cycles, where N = effective data_size.
REQ-025 Back-to-back: tx_start held high SHALL be accepted in the tx_done cycle; the next start bit SHALL begin on the following cycle, so the line is never idle between frames.
REQ-026 An input change mid-frame SHALL have no effect; only rst aborts a frame.

Reset
REQ-027 rst=1 SHALL immediately and asynchronously force state=IDLE, serial_out=1, tx_ready=1, tx_done=0, and clear all counters and captured registers.
REQ-028 A reset asserted mid-frame SHALL abort the frame, with the line returning high with no stop-bit completion.
REQ-029 After rst deasserts, a tx_start on the first rising edge SHALL be accepted normally.

Configuration
REQ-030 Macro UART_TX_PARITY_EN SHALL control parity. When defined, the PARITY state SHALL be present and an even-parity bit (XOR of the N sent data bits) SHALL be sent for P cycles between the last data bit and the stop bit.
REQ-031 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and STOP SHALL follow the last data bit directly.

Verification
REQ-032 Reset check: rst=1 mid-frame (during DATA) -> serial_out=1, tx_ready=1 and tx_done=0 within the same cycle; a frame accepted after release is correct.
REQ-033 8N1 frame: bit_period=10, data_size=8, tx_data=8'hA5 (no parity) -> line 0x10, then 1,0,1,0,0,1,0,1 (10 cycles each), then 1x10; tx_done on cycle 100 after accept.
REQ-034 Size/clamp: data_size=5, tx_data=8'hFF, bit_period=1 -> P=2; line 0x2, 1x10, 1x2; tx_done on cycle 14. Repeat with data_size=2 -> identical to size 5.
REQ-035 Busy/back-to-back: hold tx_start=1 with 8'h01 then 8'h80 (swapped on the tx_done cycle), bit_period=4 -> second start bit on the cycle after tx_done; a tx_start pulse mid-frame -> ignored, exactly 2 frames total.
REQ-036 Input isolation: change tx_data, bit_period and data_size every cycle mid-frame -> waveform matches the captured values.
REQ-037 Parity (UART_TX_PARITY_EN defined): tx_data=8'h07, data_size=8, bit_period=4 -> parity bit 1 for 4 cycles before stop; tx_done on cycle 44. With tx_data=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_if.sv
// UART transmitter handshake and line interface.
// The master side (frame producer) drives the request and frame parameters;
// the slave side (uart_tx) returns the serial line and handshake status.
interface uart_tx_if;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic        serial_out;
  logic        tx_ready;
  logic        tx_done;

  modport master (
    output tx_start, tx_data, data_size, bit_period,
    input  serial_out, tx_ready, tx_done
  );

  modport slave (
    input  tx_start, tx_data, data_size, bit_period,
    output serial_out, tx_ready, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional even
// parity, one stop bit. Each bit lasts P cycles (captured bit_period,
// minimum 2). Frame parameters are captured at accept and held for the
// whole frame. Parity is built in only when UART_TX_PARITY_EN is defined.
// The stop bit's final cycle is the IDLE/tx_done cycle, which lets a new
// frame be accepted there without leaving the line idle.
module uart_tx (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  // Index of the last data bit to send (data_size clamped to 5..8).
  function automatic logic [2:0] clamp_last(input logic [3:0] ds);
    logic [2:0] r;
    if (ds < 4'd5) begin
      r = 3'd4;
    end else if (ds > 4'd8) begin
      r = 3'd7;
    end else begin
      r = 3'(ds - 4'd1);
    end
    return r;
  endfunction

  // Cycles per bit, never below 2 so the stop state always has a cycle.
  function automatic logic [13:0] clamp_period(input logic [13:0] bp);
    logic [13:0] r;
    if (bp < 14'd2) begin
      r = 14'd2;
    end else begin
      r = bp;
    end
    return r;
  endfunction

`ifdef UART_TX_PARITY_EN
  // Even parity over data bits 0..last.
  function automatic logic even_parity(input logic [7:0] d, input logic [2:0] last);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i <= int'(last)) begin
        p = p ^ d[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction
`endif

  state_t      state_r, state_s;
  logic [13:0] cnt_r, cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [7:0]  data_r, data_s;
  logic [2:0]  last_r, last_s;
  logic [13:0] period_r, period_s;
  logic        serial_r, serial_s;
  logic        ready_r, ready_s;
  logic        done_r, done_s;
  logic        bit_end_s;
  logic        stop_end_s;
`ifdef UART_TX_PARITY_EN
  logic        parity_r, parity_s;
`endif

  assign bus.serial_out = serial_r;
  assign bus.tx_ready   = ready_r;
  assign bus.tx_done    = done_r;

  // Bit boundary detection; the stop state ends one cycle early because
  // its last cycle is spent in IDLE with tx_done high.
  always_comb begin
    bit_end_s  = (cnt_r == (period_r - 14'd1));
    stop_end_s = (cnt_r == (period_r - 14'd2));
  end

  // Next-state, counter, capture and registered-output logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + 14'd1;
    bit_idx_s = bit_idx_r;
    data_s    = data_r;
    last_s    = last_r;
    period_s  = period_r;
    serial_s  = serial_r;
    ready_s   = 1'b0;
    done_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s  = parity_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s     = 14'd0;
        bit_idx_s = 3'd0;
        if (bus.tx_start && ready_r) begin
          state_s  = START;
          data_s   = bus.tx_data;
          last_s   = clamp_last(bus.data_size);
          period_s = clamp_period(bus.bit_period);
`ifdef UART_TX_PARITY_EN
          parity_s = even_parity(bus.tx_data, clamp_last(bus.data_size));
`endif
          serial_s = 1'b0;
          ready_s  = 1'b0;
        end else begin
          state_s  = IDLE;
          serial_s = 1'b1;
          ready_s  = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          cnt_s     = 14'd0;
          bit_idx_s = 3'd0;
          serial_s  = data_r[0];
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = 14'd0;
          if (bit_idx_r == last_r) begin
            bit_idx_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_s   = PARITY;
            serial_s  = parity_r;
`else
            state_s   = STOP;
            serial_s  = 1'b1;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            serial_s  = data_r[bit_idx_r + 3'd1];
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s  = STOP;
          cnt_s    = 14'd0;
          serial_s = 1'b1;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (stop_end_s) begin
          state_s  = IDLE;
          cnt_s    = 14'd0;
          serial_s = 1'b1;
          ready_s  = 1'b1;
          done_s   = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = 14'd0;
        serial_s = 1'b1;
        ready_s  = 1'b1;
      end
    endcase
  end

  // State, counters, captured frame and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 14'd0;
      bit_idx_r <= 3'd0;
      data_r    <= 8'd0;
      last_r    <= 3'd0;
      period_r  <= 14'd0;
      serial_r  <= 1'b1;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      data_r    <= data_s;
      last_r    <= last_s;
      period_r  <= period_s;
      serial_r  <= serial_s;
      ready_r   <= ready_s;
      done_r    <= done_s;
`ifdef UART_TX_PARITY_EN
      parity_r  <= parity_s;
`endif
    end
  end

endmodule
